pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, forward-select
// codes, and the in-flight scoreboard entry.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_FREEZE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wren;
    logic              is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // A source hits an entry only for a live, writing, non-x0 producer of that register.
  function automatic logic entry_hit(input sb_entry_t e, input logic [REG_AW-1:0] src,
                                     input logic used);
    return e.valid && e.wren && (e.rd != '0) && (e.rd == src) && used;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage, control and hazard-output bundle between the pipeline and the
// hazard controller. Signal suffixes are from the controller's point of view.
interface pipe_hazard_ctrl_if;

  logic                        id_valid_i;
  logic [pipe_pkg::REG_AW-1:0] id_rs1_i;
  logic [pipe_pkg::REG_AW-1:0] id_rs2_i;
  logic                        id_rs1_used_i;
  logic                        id_rs2_used_i;
  logic [pipe_pkg::REG_AW-1:0] id_rd_i;
  logic                        id_rd_wren_i;
  logic                        id_is_load_i;
  logic                        id_is_branch_i;

  logic                        ex_br_resolve_i;
  logic                        ex_br_mispredict_i;
  logic                        mem_busy_i;

  logic                        stall_pc_o;
  logic                        stall_id_o;
  logic                        flush_id_o;
  logic                        flush_ex_o;
  logic [1:0]                  fwd_a_sel_o;
  logic [1:0]                  fwd_b_sel_o;
  logic                        fwd_cmp_a_o;
  logic                        fwd_cmp_b_o;
  logic [1:0]                  state_o;

  // Pipeline side: drives decode/control, consumes hazard decisions.
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_wren_i, id_is_load_i, id_is_branch_i,
           ex_br_resolve_i, ex_br_mispredict_i, mem_busy_i,
    input  stall_pc_o, stall_id_o, flush_id_o, flush_ex_o,
           fwd_a_sel_o, fwd_b_sel_o, fwd_cmp_a_o, fwd_cmp_b_o, state_o
  );

  // Hazard controller side.
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_wren_i, id_is_load_i, id_is_branch_i,
           ex_br_resolve_i, ex_br_mispredict_i, mem_busy_i,
    output stall_pc_o, stall_id_o, flush_id_o, flush_ex_o,
           fwd_a_sel_o, fwd_b_sel_o, fwd_cmp_a_o, fwd_cmp_b_o, state_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-source forward selection: matches one ID source against the EX/MEM/WB
// scoreboard with EX > MEM > WB priority, and flags a load sitting in EX.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  input  sb_entry_t         ex_i,
  input  sb_entry_t         mem_i,
  input  sb_entry_t         wb_i,
  output fwd_sel_e          sel_o,
  output logic              ex_load_hit_o
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_is_load;

  assign hit_ex  = entry_hit(ex_i,  src_i, used_i);
  assign hit_mem = entry_hit(mem_i, src_i, used_i);
  assign hit_wb  = entry_hit(wb_i,  src_i, used_i);

  // Youngest producer wins.
  always_comb begin
    sel_o = FWD_RF;
    if (hit_ex) begin
      sel_o = FWD_EX;
    end else if (hit_mem) begin
      sel_o = FWD_MEM;
    end else if (hit_wb) begin
      sel_o = FWD_WB;
    end
  end

  assign ex_load_hit_o  = hit_ex & ex_i.is_load;

  // Load flags only matter in EX; later stages already have data.
  assign unused_is_load = mem_i.is_load ^ wb_i.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: forwarding selects,
// load-use stall, mispredict flush and memory-busy freeze.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input logic               clk_i,
  input logic               rst_ni,
  pipe_hazard_ctrl_if.slave hz
);

  state_e    state_q, state_d;
  logic      br_pend_q, br_pend_d;
  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d, mem_d, wb_d;
  sb_entry_t id_entry;

  fwd_sel_e  sel_a, sel_b;
  logic      ld_hit_a, ld_hit_b;
  logic      mispredict;
  logic      load_use;
  logic      stall;
  logic      flush;

  fwd_sel u_fwd_rs1 (
    .src_i         (hz.id_rs1_i),
    .used_i        (hz.id_rs1_used_i),
    .ex_i          (ex_q),
    .mem_i         (mem_q),
    .wb_i          (wb_q),
    .sel_o         (sel_a),
    .ex_load_hit_o (ld_hit_a)
  );

  fwd_sel u_fwd_rs2 (
    .src_i         (hz.id_rs2_i),
    .used_i        (hz.id_rs2_used_i),
    .ex_i          (ex_q),
    .mem_i         (mem_q),
    .wb_i          (wb_q),
    .sel_o         (sel_b),
    .ex_load_hit_o (ld_hit_b)
  );

  assign mispredict = hz.ex_br_resolve_i & hz.ex_br_mispredict_i;
  assign load_use   = hz.id_valid_i & (ld_hit_a | ld_hit_b);

  // state_d is the mode this cycle runs in (stalls must act in the detection
  // cycle); state_q remembers it so a load-use stall never repeats back to back.
  always_comb begin
    state_d   = ST_RUN;
    br_pend_d = br_pend_q;
    if (hz.mem_busy_i) begin
      state_d   = ST_FREEZE;
      br_pend_d = br_pend_q | mispredict;
    end else if (mispredict || br_pend_q) begin
      state_d   = ST_FLUSH;
      br_pend_d = 1'b0;
    end else if (load_use && (state_q != ST_LDSTALL)) begin
      state_d = ST_LDSTALL;
    end
  end

  // Scoreboard advance: freeze holds, stall/flush inject a bubble, run pushes ID.
  always_comb begin
    id_entry = '{valid: 1'b1, rd: hz.id_rd_i, wren: hz.id_rd_wren_i,
                 is_load: hz.id_is_load_i};
    ex_d  = SB_BUBBLE;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (state_d == ST_FREEZE) begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end else if ((state_d == ST_RUN) && hz.id_valid_i) begin
      ex_d = id_entry;
    end
  end

  // State, pending mispredict and scoreboard registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      br_pend_q <= 1'b0;
      ex_q      <= SB_BUBBLE;
      mem_q     <= SB_BUBBLE;
      wb_q      <= SB_BUBBLE;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
    end
  end

  assign stall = (state_d == ST_LDSTALL) || (state_d == ST_FREEZE);
  assign flush = (state_d == ST_FLUSH);

  // Outputs are forced quiet while reset is held, whatever the inputs say.
  assign hz.stall_pc_o  = rst_ni & stall;
  assign hz.stall_id_o  = rst_ni & stall;
  assign hz.flush_id_o  = rst_ni & flush;
  assign hz.flush_ex_o  = rst_ni & flush;
  assign hz.fwd_a_sel_o = (rst_ni && !hz.id_is_branch_i) ? sel_a : FWD_RF;
  assign hz.fwd_b_sel_o = (rst_ni && !hz.id_is_branch_i) ? sel_b : FWD_RF;
  assign hz.fwd_cmp_a_o = rst_ni & hz.id_is_branch_i & (sel_a != FWD_RF);
  assign hz.fwd_cmp_b_o = rst_ni & hz.id_is_branch_i & (sel_b != FWD_RF);
  assign hz.state_o     = rst_ni ? state_d : ST_RUN;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected outputs.
module tb_pipe_hazard_ctrl;

  logic clk_i;
  logic rst_ni;
  int unsigned n_total;
  int unsigned n_pass;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hz     (hz.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Packed order: stall_pc stall_id flush_id flush_ex fwd_a fwd_b cmp_a cmp_b state
  task automatic chk_outs(input string tag, input logic sp, input logic si,
                          input logic fi, input logic fe,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic ca, input logic cb, input logic [1:0] st);
    chk(tag,
        {hz.stall_pc_o, hz.stall_id_o, hz.flush_id_o, hz.flush_ex_o,
         hz.fwd_a_sel_o, hz.fwd_b_sel_o, hz.fwd_cmp_a_o, hz.fwd_cmp_b_o, hz.state_o},
        {sp, si, fi, fe, fa, fb, ca, cb, st});
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic br);
    hz.id_valid_i     = v;
    hz.id_rs1_i       = rs1;
    hz.id_rs2_i       = rs2;
    hz.id_rs1_used_i  = u1;
    hz.id_rs2_used_i  = u2;
    hz.id_rd_i        = rd;
    hz.id_rd_wren_i   = wr;
    hz.id_is_load_i   = ld;
    hz.id_is_branch_i = br;
  endtask

  task automatic ctl(input logic res, input logic misp, input logic busy);
    hz.ex_br_resolve_i    = res;
    hz.ex_br_mispredict_i = misp;
    hz.mem_busy_i         = busy;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      ctl(1'b0, 1'b0, 1'b0);
      nxt();
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Reset with noisy inputs: outputs must stay quiet.
    rst_ni = 1'b0;
    drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    ctl(1'b1, 1'b1, 1'b1);
    nxt();
    nxt();
    settle();
    chk_outs("reset_quiet", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0);
    nxt();
    rst_ni = 1'b1;
    ctl(1'b0, 1'b0, 1'b0);

    // ALU forwarding from EX, MEM, WB and priority.
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("first_after_reset", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("fwd_ex_add_sub", 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("fwd_mem_ex", 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("fwd_wb_mem", 0, 0, 0, 0, 2'd3, 2'd2, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd8, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    settle(); chk_outs("used_bit_gate", 0, 0, 0, 0, 2'd0, 2'd2, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    settle(); chk_outs("wren_gate", 0, 0, 0, 0, 2'd3, 2'd2, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    nxt();
    drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("fwd_ex_x9", 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 2'd0); nxt();
    drive_id(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle(); chk_outs("prio_ex_over_mem", 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 2'd0); nxt();
    settle(); chk_outs("prio_mem_over_wb", 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 2'd0); nxt();
    settle(); chk_outs("bubble_drain_wb", 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 2'd0); nxt();
    settle(); chk_outs("bubble_drained", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();

    // Load-use: one stall cycle, then MEM forward.
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    settle(); chk_outs("lw_issue", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("ldstall", 1, 1, 0, 0, 2'd0, 2'd1, 0, 0, 2'd1); nxt();
    settle(); chk_outs("ldstall_release", 0, 0, 0, 0, 2'd0, 2'd2, 0, 0, 2'd0); nxt();
    idle(3);

    // Mispredict beats load-use; mispredict without resolve is ignored.
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    nxt();
    drive_id(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    ctl(1'b1, 1'b1, 1'b0);
    settle(); chk_outs("flush_over_ldstall", 0, 0, 1, 1, 2'd0, 2'd1, 0, 0, 2'd2); nxt();
    drive_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    ctl(1'b0, 1'b1, 1'b0);
    settle(); chk_outs("after_flush_no_resolve", 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 2'd0); nxt();
    idle(3);

    // Freeze for 3 cycles with a mispredict in the second, then flush.
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    nxt();
    drive_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    ctl(1'b0, 1'b0, 1'b1);
    settle(); chk_outs("freeze_c1", 1, 1, 0, 0, 2'd1, 2'd0, 0, 0, 2'd3); nxt();
    ctl(1'b1, 1'b1, 1'b1);
    settle(); chk_outs("freeze_c2_misp", 1, 1, 0, 0, 2'd1, 2'd0, 0, 0, 2'd3); nxt();
    ctl(1'b0, 1'b0, 1'b1);
    settle(); chk_outs("freeze_c3", 1, 1, 0, 0, 2'd1, 2'd0, 0, 0, 2'd3); nxt();
    ctl(1'b0, 1'b0, 1'b0);
    settle(); chk_outs("latched_flush", 0, 0, 1, 1, 2'd1, 2'd0, 0, 0, 2'd2); nxt();
    drive_id(1'b0, 5'd11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle(); chk_outs("post_freeze_run", 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 2'd0); nxt();
    idle(3);

    // x0 producers never forward or stall.
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    nxt();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("x0_after_load", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    nxt();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    settle(); chk_outs("x0_all_stages", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();

    // Branch operands use the compare forward instead of the ALU select.
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    nxt();
    drive_id(1'b1, 5'd12, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    settle(); chk_outs("branch_cmp_fwd", 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0); nxt();

    // Reset arriving during a load-use stall.
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    nxt();
    drive_id(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    settle(); chk_outs("ldstall_pre_reset", 1, 1, 0, 0, 2'd0, 2'd1, 0, 0, 2'd1);
    rst_ni = 1'b0;
    nxt();
    ctl(1'b1, 1'b1, 1'b1);
    settle(); chk_outs("reset_mid_stall", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();
    rst_ni = 1'b1;
    ctl(1'b0, 1'b0, 1'b0);
    settle(); chk_outs("sb_cleared_by_reset", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0); nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
